// File: rtl/ext_irq_pkg.sv
// Shared definitions for the external interrupt controller: register word map,
// interrupt ID width and gateway state encoding.
package ext_irq_pkg;

  localparam int ID_W = 5;

  // Word indices (byte address >> 2)
  localparam logic [5:0] WORD_PENDING   = 6'h00;
  localparam logic [5:0] WORD_ENABLE    = 6'h01;
  localparam logic [5:0] WORD_EDGE      = 6'h02;
  localparam logic [5:0] WORD_THRESHOLD = 6'h03;
  localparam logic [5:0] WORD_CLAIM     = 6'h04;
  localparam logic [5:0] WORD_PRIO_BASE = 6'h10;

  typedef enum logic {
    GW_IDLE      = 1'b0,
    GW_IN_FLIGHT = 1'b1
  } gw_state_e;

endpackage

// File: rtl/ext_irq_controller_if.sv
// Register access port of the external interrupt controller.
interface ext_irq_controller_if;
  logic        bus_req;
  logic        bus_we;
  logic [7:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  modport master (output bus_req, bus_we, bus_addr, bus_wdata,
                  input  bus_rdata, bus_ack);
  modport slave  (input  bus_req, bus_we, bus_addr, bus_wdata,
                  output bus_rdata, bus_ack);
endinterface

// File: rtl/ext_irq_gateway.sv
// Per-source gateway: synchroniser, edge/level qualification, pending flop and claim FSM.
//   state        | meaning
//   GW_IDLE      | source may raise pending; a claim moves it in flight
//   GW_IN_FLIGHT | claimed by the core, new requests dropped until complete
module ext_irq_gateway
  import ext_irq_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic src,
  input  logic edge_mode,
  input  logic claim,
  input  logic complete,
  output logic pending
);

  logic      sync_q1, sync_q2, prev_q;
  gw_state_e state_q;
  logic      trigger, done;

  assign trigger = edge_mode ? (sync_q2 & ~prev_q) : sync_q2;
  // A complete landing with the claim of the same ID still counts, and wins.
  assign done    = complete & ((state_q == GW_IN_FLIGHT) | claim);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      prev_q  <= 1'b0;
      pending <= 1'b0;
      state_q <= GW_IDLE;
    end else begin
      sync_q1 <= src;
      sync_q2 <= sync_q1;
      prev_q  <= sync_q2;
      case (state_q)
        GW_IDLE: begin
          if (done) begin
            pending <= 1'b0;
          end else if (claim) begin
            pending <= 1'b0;
            state_q <= GW_IN_FLIGHT;
          end else if (trigger) begin
            pending <= 1'b1;
          end
        end
        GW_IN_FLIGHT: begin
          if (done) state_q <= GW_IDLE;
        end
        default: state_q <= GW_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/ext_irq_controller.sv
// External interrupt controller: register file, priority arbiter, claim/complete
// handling and meip generation over NUM_SRC gateways.
module ext_irq_controller
  import ext_irq_pkg::*;
#(
  parameter int NUM_SRC = 16,
  parameter int PRIO_W  = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_SRC-1:0]   src_i,
  input  logic                 irq_ack,
  ext_irq_controller_if.slave  bus,
  output logic                 meip,
  output logic [ID_W-1:0]      claim_id
);

  logic [NUM_SRC-1:0] pending, enable_q, edge_q, claim_vec, complete_vec;
  logic [PRIO_W-1:0]  threshold_q;
  logic [PRIO_W-1:0]  prio_q [NUM_SRC];
  logic [PRIO_W-1:0]  best_prio;
  logic [ID_W-1:0]    best_id;
  logic [5:0]         word;
  logic [31:0]        rd_data;
  logic               claim_evt, complete_evt;
  logic               unused_addr_bits;

  assign word             = bus.bus_addr[7:2];
  assign unused_addr_bits = ^bus.bus_addr[1:0];
  assign claim_evt        = irq_ack | (bus.bus_req & ~bus.bus_we & (word == WORD_CLAIM));
  assign complete_evt     = bus.bus_req & bus.bus_we & (word == WORD_CLAIM);

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_gw
    ext_irq_gateway u_gw (
      .clk       (clk),
      .reset     (reset),
      .src       (src_i[k]),
      .edge_mode (edge_q[k]),
      .claim     (claim_vec[k]),
      .complete  (complete_vec[k]),
      .pending   (pending[k])
    );
  end

  // Strict > keeps the lowest ID on equal priority.
  always_comb begin
    best_id   = '0;
    best_prio = threshold_q;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (pending[k] && enable_q[k] && (prio_q[k] > best_prio)) begin
        best_prio = prio_q[k];
        best_id   = ID_W'(k + 1);
      end
    end
  end

  always_comb begin
    claim_vec    = '0;
    complete_vec = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      claim_vec[k]    = claim_evt && (best_id == ID_W'(k + 1));
      complete_vec[k] = complete_evt && (bus.bus_wdata == 32'(k + 1));
    end
  end

  always_comb begin
    rd_data = '0;
    case (word)
      WORD_PENDING:   rd_data = 32'(pending);
      WORD_ENABLE:    rd_data = 32'(enable_q);
      WORD_EDGE:      rd_data = 32'(edge_q);
      WORD_THRESHOLD: rd_data = 32'(threshold_q);
      WORD_CLAIM:     rd_data = 32'(best_id);
      default: begin
        for (int k = 0; k < NUM_SRC; k++)
          if (word == WORD_PRIO_BASE + 6'(k)) rd_data = 32'(prio_q[k]);
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enable_q      <= '0;
      edge_q        <= '0;
      threshold_q   <= '0;
      for (int k = 0; k < NUM_SRC; k++) prio_q[k] <= '0;
      meip          <= 1'b0;
      claim_id      <= '0;
      bus.bus_ack   <= 1'b0;
      bus.bus_rdata <= '0;
    end else begin
      bus.bus_ack   <= bus.bus_req;
      bus.bus_rdata <= (bus.bus_req && !bus.bus_we) ? rd_data : '0;
      meip          <= (best_id != '0);
      if (claim_evt) claim_id <= best_id;
      if (bus.bus_req && bus.bus_we) begin
        case (word)
          WORD_ENABLE:    enable_q    <= bus.bus_wdata[NUM_SRC-1:0];
          WORD_EDGE:      edge_q      <= bus.bus_wdata[NUM_SRC-1:0];
          WORD_THRESHOLD: threshold_q <= bus.bus_wdata[PRIO_W-1:0];
          default: begin
            for (int k = 0; k < NUM_SRC; k++)
              if (word == WORD_PRIO_BASE + 6'(k)) prio_q[k] <= bus.bus_wdata[PRIO_W-1:0];
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ext_irq_controller.sv
// Directed bench for ext_irq_controller: level/edge gateways, arbitration, claim/complete, reset.
module tb_ext_irq_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] src_i = '0;
  logic        irq_ack = 1'b0;
  logic        meip;
  logic [4:0]  claim_id;
  logic [31:0] rd;
  int          n_cmp = 0;
  int          n_err = 0;

  ext_irq_controller_if bus_if ();

  always #5 clk = ~clk;

  ext_irq_controller #(.NUM_SRC(16), .PRIO_W(3)) dut (
    .clk      (clk),
    .reset    (reset),
    .src_i    (src_i),
    .irq_ack  (irq_ack),
    .bus      (bus_if),
    .meip     (meip),
    .claim_id (claim_id)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    bus_if.bus_req = 1'b1; bus_if.bus_we = 1'b1; bus_if.bus_addr = a; bus_if.bus_wdata = d;
    @(negedge clk);
    bus_if.bus_req = 1'b0; bus_if.bus_we = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
    @(negedge clk);
    bus_if.bus_req = 1'b1; bus_if.bus_we = 1'b0; bus_if.bus_addr = a;
    @(negedge clk);
    bus_if.bus_req = 1'b0;
    d = bus_if.bus_rdata;
  endtask

  task automatic read_check(input string tag, input logic [7:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(a, d);
    check_val(tag, d, exp);
  endtask

  task automatic pulse_src(input int idx);
    @(negedge clk);
    src_i[idx] = 1'b1;
    repeat (2) @(negedge clk);
    src_i[idx] = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic ack_pulse();
    @(negedge clk);
    irq_ack = 1'b1;
    @(negedge clk);
    irq_ack = 1'b0;
  endtask

  initial begin
    bus_if.bus_req = 1'b0; bus_if.bus_we = 1'b0;
    bus_if.bus_addr = '0;  bus_if.bus_wdata = '0;

    // 1: reset state, level source latency, CLAIM read
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_val("rst_meip", meip, 0);
    check_val("rst_claim_id", claim_id, 0);
    check_val("rst_ack", bus_if.bus_ack, 0);
    check_val("rst_rdata", bus_if.bus_rdata, 0);
    bus_write(8'h48, 2);
    bus_write(8'h04, 32'h4);
    check_val("wr_ack", bus_if.bus_ack, 1);
    @(negedge clk);
    src_i[2] = 1'b1;
    repeat (3) @(negedge clk);
    check_val("t1_meip_edge3", meip, 0);
    @(negedge clk);
    check_val("t1_meip_edge4", meip, 1);
    read_check("t1_claim_rd", 8'h10, 3);
    check_val("t1_claim_id", claim_id, 3);
    @(negedge clk);
    check_val("t1_meip_after_claim", meip, 0);
    src_i[2] = 1'b0;
    repeat (4) @(negedge clk);
    bus_write(8'h10, 3);
    read_check("t1_pending_clear", 8'h00, 0);
    read_check("t1_prio_rd", 8'h48, 2);
    read_check("unmapped_rd", 8'h20, 0);

    // 2: tie at priority 4 -> lowest ID first, then the other after complete
    bus_write(8'h44, 4);
    bus_write(8'h50, 4);
    bus_write(8'h0C, 1);
    bus_write(8'h08, 32'h12);
    bus_write(8'h04, 32'h12);
    @(negedge clk);
    src_i[1] = 1'b1; src_i[4] = 1'b1;
    repeat (2) @(negedge clk);
    src_i[1] = 1'b0; src_i[4] = 1'b0;
    repeat (4) @(negedge clk);
    read_check("t2_pending", 8'h00, 32'h12);
    check_val("t2_meip", meip, 1);
    ack_pulse();
    check_val("t2_claim_2", claim_id, 2);
    read_check("t2_pending_after", 8'h00, 32'h10);
    bus_write(8'h10, 2);
    ack_pulse();
    check_val("t2_claim_5", claim_id, 5);
    bus_write(8'h10, 5);
    read_check("t2_pending_empty", 8'h00, 0);

    // 3: threshold gating
    bus_write(8'h0C, 32'hC);   // truncates to 4
    read_check("t3_thr_trunc", 8'h0C, 4);
    bus_write(8'h40, 4);
    bus_write(8'h04, 32'h1);
    @(negedge clk);
    src_i[0] = 1'b1;
    repeat (6) @(negedge clk);
    check_val("t3_meip_gated", meip, 0);
    read_check("t3_pending", 8'h00, 32'h1);
    bus_write(8'h0C, 3);
    @(negedge clk);
    check_val("t3_meip_open", meip, 1);
    read_check("t3_claim_rd", 8'h10, 1);
    src_i[0] = 1'b0;
    repeat (4) @(negedge clk);
    bus_write(8'h10, 1);

    // 4: edge mode, edges while in flight are dropped
    bus_write(8'h08, 32'h1);
    pulse_src(0);
    ack_pulse();
    check_val("t4_claim_1", claim_id, 1);
    pulse_src(0);
    pulse_src(0);
    pulse_src(0);
    read_check("t4_pending_inflight", 8'h00, 0);
    bus_write(8'h10, 1);
    repeat (5) @(negedge clk);
    read_check("t4_pending_after", 8'h00, 0);
    check_val("t4_meip", meip, 0);
    read_check("t4_no_reclaim", 8'h10, 0);
    check_val("t4_claim_id0", claim_id, 0);

    // 5: simultaneous irq_ack and CLAIM read; stray complete of ID 7
    bus_write(8'h54, 5);
    bus_write(8'h08, 32'h20);
    bus_write(8'h04, 32'h20);
    pulse_src(5);
    @(negedge clk);
    irq_ack = 1'b1;
    bus_if.bus_req = 1'b1; bus_if.bus_we = 1'b0; bus_if.bus_addr = 8'h10;
    @(negedge clk);
    irq_ack = 1'b0; bus_if.bus_req = 1'b0;
    rd = bus_if.bus_rdata;
    check_val("t5_rdata", rd, 6);
    check_val("t5_claim_id", claim_id, 6);
    read_check("t5_single_claim", 8'h00, 0);
    bus_write(8'h10, 7);
    pulse_src(5);
    read_check("t5_still_inflight", 8'h00, 0);
    bus_write(8'h10, 6);
    pulse_src(5);
    read_check("t5_repend", 8'h00, 32'h20);

    // 6: async reset with ID 4 in flight and meip high
    bus_write(8'h4C, 5);
    bus_write(8'h04, 32'h28);
    @(negedge clk);
    src_i[3] = 1'b1;
    repeat (5) @(negedge clk);
    read_check("t6_pending", 8'h00, 32'h28);
    ack_pulse();
    check_val("t6_claim_4", claim_id, 4);
    repeat (2) @(negedge clk);
    check_val("t6_meip_before", meip, 1);
    #2;
    reset = 1'b1;
    #1;
    check_val("t6_meip_async", meip, 0);
    check_val("t6_claim_id_rst", claim_id, 0);
    src_i = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    read_check("t6_pending_rd", 8'h00, 0);
    read_check("t6_enable_rd", 8'h04, 0);
    read_check("t6_edge_rd", 8'h08, 0);
    read_check("t6_thr_rd", 8'h0C, 0);
    read_check("t6_prio4_rd", 8'h4C, 0);
    read_check("t6_claim_rd", 8'h10, 0);
    check_val("t6_meip_after", meip, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
